// File: rtl/cpu_pkg.sv
// Shared CPU types: PC/instruction widths, fetch FSM encoding,
// IF/ID bundle and the halt opcode.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [3:0] HLT_OPCODE = 4'hF;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DRAIN  = 2'd1,
        S_SKID   = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic   valid;
        instr_t instr;
        pc_t    pc_plus2;
    } if_id_t;

    function automatic logic is_hlt(
        input instr_t     ins,
        input logic [3:0] op
    );
        return ins[INSTR_W-1 -: 4] == op;
    endfunction

endpackage

// File: rtl/dff.sv
// Generic enable flop with synchronous active-high reset.
// Ports: clk, rst, en, d -> q (WIDTH bits, reset to RST_VAL).
module dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ifid_reg.sv
// IF/ID pipeline register built from dff cells.
// Ports: clk, rst, en (load d), clr (sync clear, beats en), d -> q.
module ifid_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr,
    input  if_id_t d,
    output if_id_t q
);

    localparam int W = $bits(if_id_t);

    logic [W-1:0] d_vec;
    logic [W-1:0] q_vec;

    assign d_vec = clr ? '0 : d;

    dff #(
        .WIDTH   (W),
        .RST_VAL ('0)
    ) u_dff (
        .clk (clk),
        .rst (rst),
        .en  (en | clr),
        .d   (d_vec),
        .q   (q_vec)
    );

    assign q = q_vec;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: FETCH/DRAIN/SKID/HALTED FSM, one-entry skid
// buffer for stalled responses and the IF/ID register.
// Ports: clk, rst; imem_req/addr out, imem_valid/data in;
// stall, redirect, redirect_pc in; ifid_* and fetch_halted out.
module fetch_stage #(
    parameter logic [cpu_pkg::PC_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]               HLT_OPCODE = cpu_pkg::HLT_OPCODE
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [cpu_pkg::PC_W-1:0]      imem_addr,
    input  logic                          imem_valid,
    input  logic [cpu_pkg::INSTR_W-1:0]   imem_data,
    input  logic                          stall,
    input  logic                          redirect,
    input  logic [cpu_pkg::PC_W-1:0]      redirect_pc,
    output logic                          ifid_valid,
    output logic [cpu_pkg::INSTR_W-1:0]   ifid_instr,
    output logic [cpu_pkg::PC_W-1:0]      ifid_pc_plus2,
    output logic                          fetch_halted
);

    import cpu_pkg::*;

    fetch_state_t state_q;
    pc_t          pc_q;
    if_id_t       skid_q;
    if_id_t       ifid_q;
    if_id_t       ifid_d;
    logic         ifid_en;
    logic         ifid_clr;

    pc_t  pc_plus2;
    logic resp_hlt;
    logic skid_hlt;

    assign pc_plus2 = pc_q + 16'd2;
    assign resp_hlt = is_hlt(imem_data, HLT_OPCODE);
    assign skid_hlt = is_hlt(skid_q.instr, HLT_OPCODE);

    // Gated by rst so nothing is requested in the reset cycle.
    assign imem_req     = (state_q == S_FETCH) && !rst;
    assign imem_addr    = pc_q;
    assign fetch_halted = (state_q == S_HALTED);

    // When not stalled and nothing new arrives, downstream has
    // consumed the entry: drop valid, keep the payload.
    always_comb begin
        ifid_clr = redirect;
        ifid_en  = !stall;
        ifid_d   = ifid_q;
        ifid_d.valid = 1'b0;
        unique case (1'b1)
            (state_q == S_FETCH) && imem_valid: begin
                ifid_d.valid    = 1'b1;
                ifid_d.instr    = imem_data;
                ifid_d.pc_plus2 = pc_plus2;
            end
            (state_q == S_SKID): begin
                ifid_d = skid_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            skid_q  <= '0;
        end else if (redirect) begin
            pc_q   <= redirect_pc;
            skid_q <= '0;
            // A request still in flight must be drained first.
            if ((state_q == S_FETCH || state_q == S_DRAIN) && !imem_valid)
                state_q <= S_DRAIN;
            else
                state_q <= S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        // HLT leaves pc on its own address.
                        if (!resp_hlt)
                            pc_q <= pc_plus2;
                        if (stall) begin
                            skid_q.valid    <= 1'b1;
                            skid_q.instr    <= imem_data;
                            skid_q.pc_plus2 <= pc_plus2;
                            state_q         <= S_SKID;
                        end else begin
                            state_q <= resp_hlt ? S_HALTED : S_FETCH;
                        end
                    end
                end
                S_SKID: begin
                    if (!stall) begin
                        skid_q  <= '0;
                        state_q <= skid_hlt ? S_HALTED : S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_valid)
                        state_q <= S_FETCH;
                end
                S_HALTED: ;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    ifid_reg u_ifid (
        .clk (clk),
        .rst (rst),
        .en  (ifid_en),
        .clr (ifid_clr),
        .d   (ifid_d),
        .q   (ifid_q)
    );

    assign ifid_valid    = ifid_q.valid;
    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc_plus2 = ifid_q.pc_plus2;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency
// instruction memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        fetch_halted;

    int checks = 0;
    int failures = 0;
    int lat = 1;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_data     (imem_data),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .fetch_halted  (fetch_halted)
    );

    logic [15:0] mem [logic [15:0]];

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (mem.exists(a))
            return mem[a];
        return {4'h1, a[11:0]};
    endfunction

    logic        busy;
    int          cnt;
    logic [15:0] ma;

    always @(posedge clk) begin
        if (rst) begin
            imem_valid <= 1'b0;
            imem_data  <= 16'h0000;
            busy       <= 1'b0;
            cnt        <= 0;
            ma         <= 16'h0000;
        end else begin
            imem_valid <= 1'b0;
            if (busy) begin
                if (cnt <= 1) begin
                    imem_valid <= 1'b1;
                    imem_data  <= rd(ma);
                    busy       <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (imem_req && !imem_valid) begin
                ma <= imem_addr;
                if (lat <= 1) begin
                    imem_valid <= 1'b1;
                    imem_data  <= rd(imem_addr);
                end else begin
                    busy <= 1'b1;
                    cnt  <= lat - 1;
                end
            end
        end
    end

    task automatic check(
        input string       tag,
        input logic [15:0] got,
        input logic [15:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_v"},   {15'd0, ifid_valid},   16'd0);
        check({tag, "_i"},   ifid_instr,            16'h0000);
        check({tag, "_p"},   ifid_pc_plus2,         16'h0000);
        check({tag, "_h"},   {15'd0, fetch_halted}, 16'd0);
        check({tag, "_req"}, {15'd0, imem_req},     16'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        check_reset(tag);
        rst = 1'b0;
        #1;
        check({tag, "_req1"}, {15'd0, imem_req}, 16'd1);
        check({tag, "_addr"}, imem_addr,         16'h0000);
    endtask

    task automatic wait_load(
        input string       tag,
        input logic [15:0] ei,
        input logic [15:0] ep
    );
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifid_valid && n < 40);
        check({tag, "_v"}, {15'd0, ifid_valid}, 16'd1);
        check({tag, "_i"}, ifid_instr,          ei);
        check({tag, "_p"}, ifid_pc_plus2,       ep);
    endtask

    initial begin
        int  n;
        logic seen;

        mem[16'h0000] = 16'h1000;
        mem[16'h0002] = 16'h2000;
        mem[16'h0004] = 16'h3000;
        mem[16'h0008] = 16'h5008;
        mem[16'h000A] = 16'hF000;
        mem[16'h0040] = 16'h4040;

        // Latency-1 stream.
        lat = 1;
        do_reset("rst1");
        wait_load("s1", 16'h1000, 16'h0002);
        wait_load("s2", 16'h2000, 16'h0004);
        wait_load("s3", 16'h3000, 16'h0006);

        // Stall at second response, latency 3.
        lat = 3;
        do_reset("rst2");
        wait_load("k1", 16'h1000, 16'h0002);
        n = 0;
        while (!imem_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("k_resp", {15'd0, imem_valid}, 16'd1);
        stall = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem_req) seen = 1'b1;
        end
        check("k_noreq", {15'd0, seen},       16'd0);
        check("k_hold",  ifid_instr,          16'h1000);
        check("k_holdv", {15'd0, ifid_valid}, 16'd0);
        check("k_pc",    imem_addr,           16'h0004);
        stall = 1'b0;
        @(negedge clk);
        check("k2_v", {15'd0, ifid_valid}, 16'd1);
        check("k2_i", ifid_instr,          16'h2000);
        check("k2_p", ifid_pc_plus2,       16'h0004);
        check("k2_req", {15'd0, imem_req}, 16'd1);
        wait_load("k3", 16'h3000, 16'h0006);

        // Redirect with request outstanding.
        do_reset("rst3");
        n = 0;
        while (!(imem_req && imem_addr == 16'h0008) && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("r_at8", imem_addr, 16'h0008);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        check("r_drain_req", {15'd0, imem_req}, 16'd0);
        seen = 1'b0;
        n = 0;
        while (!imem_req && n < 20) begin
            if (ifid_valid) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check("r_gapv", {15'd0, seen},     16'd0);
        check("r_req",  {15'd0, imem_req}, 16'd1);
        check("r_addr", imem_addr,         16'h0040);
        wait_load("r_ld", 16'h4040, 16'h0042);

        // HLT at 0x000A, then resume.
        lat = 1;
        do_reset("rst4");
        n = 0;
        while (!fetch_halted && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("h_halt", {15'd0, fetch_halted}, 16'd1);
        check("h_i",    ifid_instr,            16'hF000);
        check("h_pc",   imem_addr,             16'h000A);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req) seen = 1'b1;
            @(negedge clk);
        end
        check("h_noreq", {15'd0, seen},     16'd0);
        check("h_pch",   imem_addr,         16'h000A);
        redirect = 1'b1;
        redirect_pc = 16'h0020;
        @(negedge clk);
        redirect = 1'b0;
        check("h_res_h",   {15'd0, fetch_halted}, 16'd0);
        check("h_res_req", {15'd0, imem_req},     16'd1);
        check("h_res_a",   imem_addr,             16'h0020);
        check("h_res_v",   {15'd0, ifid_valid},   16'd0);
        wait_load("h_ld", 16'h1020, 16'h0022);

        // Redirect on a response, PC wrap, reset during DRAIN.
        do_reset("rst5");
        n = 0;
        while (!imem_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        check("w_req",  {15'd0, imem_req},   16'd1);
        check("w_addr", imem_addr,           16'hFFFE);
        check("w_v",    {15'd0, ifid_valid}, 16'd0);
        wait_load("w_ld", 16'h1FFE, 16'h0000);
        check("w_wrap", imem_addr, 16'h0000);
        lat = 3;
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        redirect = 1'b0;
        check("d_req", {15'd0, imem_req}, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("d_rst");
        rst = 1'b0;
        #1;
        check("d_req1", {15'd0, imem_req}, 16'd1);
        check("d_addr", imem_addr,         16'h0000);
        wait_load("d_ld", 16'h1000, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
